// File: rtl/relu_serializer_if.sv
// Handshake bundle for relu_serializer: packed vector in, lane beats out.
`ifndef WD
`define WD 8
`endif

interface relu_serializer_if #(
    parameter int INPUT_NUM = 6,
    parameter int IDX_W     = 3
);
    logic                      in_valid;
    logic                      in_ready;
    logic [`WD*INPUT_NUM-1:0]  in_data;
    logic                      skip_zero;
    logic                      out_valid;
    logic                      out_ready;
    logic [`WD-1:0]            out_data;
    logic [IDX_W-1:0]          out_idx;
    logic                      out_last;
    logic                      busy;

    modport master (
        output in_valid, in_data, skip_zero, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, skip_zero, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy
    );
endinterface

// File: rtl/relu_serializer.sv
// Lane-serial reader for packed ReLU outputs.
// Optionally drops zero lanes; every vector still yields exactly one last beat.
`ifndef WD
`define WD 8
`endif

module relu_serializer #(
    parameter int INPUT_NUM = 6,
    parameter int IDX_W     = 3
) (
    input  logic            clk,
    input  logic            rst,
    relu_serializer_if.slave bus
);
    localparam int W = `WD;
    localparam logic [INPUT_NUM-1:0] TOP_LANE =
        INPUT_NUM'(1) << (INPUT_NUM - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state;
    logic [W*INPUT_NUM-1:0] data;
    logic [INPUT_NUM-1:0] mask;

    logic [INPUT_NUM-1:0] nz;
    logic [INPUT_NUM-1:0] new_mask;
    logic [INPUT_NUM-1:0] rest;
    logic [IDX_W-1:0]     idx;
    logic [W-1:0]         lane;
    logic                 last;
    logic                 beat;
    logic                 accept;

    always_comb begin
        nz = '0;
        for (int i = 0; i < INPUT_NUM; i++) begin
            nz[i] = |bus.in_data[i*W +: W];
        end
        if (!bus.skip_zero) begin
            new_mask = '1;
        end else if (nz == '0) begin
            new_mask = TOP_LANE;
        end else begin
            new_mask = nz;
        end
    end

    // Lowest set bit of the remaining mask selects the lane on the bus.
    always_comb begin
        idx  = '0;
        lane = '0;
        for (int i = INPUT_NUM - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx  = IDX_W'(i);
                lane = data[i*W +: W];
            end
        end
        rest = mask & (mask - INPUT_NUM'(1));
        last = (rest == '0);
    end

    always_comb begin
        bus.out_valid = (state == SEND);
        bus.out_data  = bus.out_valid ? lane : '0;
        bus.out_idx   = bus.out_valid ? idx : '0;
        bus.out_last  = bus.out_valid && last;
        bus.busy      = (state == SEND);
        beat          = bus.out_valid && bus.out_ready;
        bus.in_ready  = !rst && ((state == IDLE) || (beat && last));
        accept        = bus.in_valid && bus.in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            data  <= '0;
            mask  <= '0;
        end else if (accept) begin
            state <= SEND;
            data  <= bus.in_data;
            mask  <= new_mask;
        end else if (beat) begin
            mask <= rest;
            if (last) begin
                state <= IDLE;
            end
        end
    end
endmodule
